// File: rtl/rom_dl_dispatch.sv
// ioctl download dispatcher: buffers bytes and routes them to sdram port1/port2 or the dl_* strobe.
// Also owns rom_loaded and core_reset. Define ROM_DL_CHECKSUM_EN to add the dl_sum byte-sum output.
module rom_dl_dispatch #(
   parameter logic [24:0] SP_BASE    = 25'h12000,
   parameter logic [24:0] DL_BASE    = 25'h32000,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] RST_HOLD   = 16'hFFFF
) (
   input  logic        clk_sys,
   input  logic        RESET,
   input  logic        ext_reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        port1_req,
   input  logic        port1_ack,
   output logic [22:0] port1_a,
   output logic [1:0]  port1_ds,
   output logic [15:0] port1_d,
   output logic        port2_req,
   input  logic        port2_ack,
   output logic [22:0] port2_a,
   output logic [1:0]  port2_ds,
   output logic [15:0] port2_d,
   output logic [24:0] dl_addr,
   output logic        dl_wr,
   output logic [7:0]  dl_data,
   output logic        fifo_ovf,
   output logic        rom_loaded,
   output logic        core_reset
`ifdef ROM_DL_CHECKSUM_EN
   ,
   output logic [15:0] dl_sum
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT1, S_WAIT2, S_DL} state_t;

   state_t state_q, state_d;

   logic [32:0]   fifo_mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          wr_prev_q, dl_prev_q, end_pend_q, end_pend_d;
   logic          fifo_ovf_q, fifo_ovf_d, rom_loaded_q, rom_loaded_d;
   logic          core_reset_q, core_reset_d;
   logic [15:0]   rst_cnt_q, rst_cnt_d;
   logic          port1_req_q, port1_req_d, port2_req_q, port2_req_d, dl_wr_q, dl_wr_d;
   logic [22:0]   port1_a_q, port1_a_d, port2_a_q, port2_a_d;
   logic [1:0]    port1_ds_q, port1_ds_d, port2_ds_q, port2_ds_d;
   logic [15:0]   port1_d_q, port1_d_d, port2_d_q, port2_d_d;
   logic [24:0]   dl_addr_q, dl_addr_d;
   logic [7:0]    dl_data_q, dl_data_d;

   logic          push_req, push, pop, fifo_empty, fifo_full, dl_rise, dl_fall, hold_rst;
   logic          is_p1, is_p2;
   logic [24:0]   head_addr;
   logic [7:0]    head_data;
   logic [18:0]   sp_off;

   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
   assign push_req   = ioctl_download & ioctl_wr & ~wr_prev_q;
   assign pop        = (state_q == S_IDLE) & ~fifo_empty;
   assign push       = push_req & (~fifo_full | pop);
   assign dl_rise    = ioctl_download & ~dl_prev_q;
   assign dl_fall    = ~ioctl_download & dl_prev_q;
   assign hold_rst   = ext_reset | ~rom_loaded_q;

   assign {head_addr, head_data} = fifo_mem_q[rd_ptr_q];
   assign is_p1  = (head_addr < SP_BASE);
   assign is_p2  = ~is_p1 & (head_addr < DL_BASE);
   assign sp_off = 19'(head_addr - SP_BASE);

   always_ff @(posedge clk_sys) begin
      if (RESET) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!fifo_empty) state_d = is_p1 ? S_WAIT1 : (is_p2 ? S_WAIT2 : S_DL);
         S_WAIT1: if (port1_ack == port1_req_q) state_d = S_IDLE;
         S_WAIT2: if (port2_ack == port2_req_q) state_d = S_IDLE;
         S_DL:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Pop, classify and issue share one clock so an idle FIFO reaches the request two cycles after the strobe.
   always_comb begin
      port1_req_d = port1_req_q;
      port1_a_d   = port1_a_q;
      port1_ds_d  = port1_ds_q;
      port1_d_d   = port1_d_q;
      port2_req_d = port2_req_q;
      port2_a_d   = port2_a_q;
      port2_ds_d  = port2_ds_q;
      port2_d_d   = port2_d_q;
      dl_addr_d   = dl_addr_q;
      dl_data_d   = dl_data_q;
      dl_wr_d     = 1'b0;
      if (pop) begin
         if (is_p1) begin
            port1_a_d   = head_addr[23:1];
            port1_ds_d  = {head_addr[0], ~head_addr[0]};
            port1_d_d   = {head_data, head_data};
            port1_req_d = ~port1_req_q;
         end else if (is_p2) begin
            port2_a_d   = {5'b0, sp_off[18:17], sp_off[14:0], sp_off[16]};
            port2_ds_d  = {sp_off[15], ~sp_off[15]};
            port2_d_d   = {head_data, head_data};
            port2_req_d = ~port2_req_q;
         end else begin
            dl_addr_d = head_addr - DL_BASE;
            dl_data_d = head_data;
            dl_wr_d   = 1'b1;
         end
      end
   end

   always_comb begin
      wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d        = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      fifo_ovf_d   = fifo_ovf_q | (push_req & fifo_full & ~pop);
      end_pend_d   = end_pend_q;
      rom_loaded_d = rom_loaded_q;
      if (dl_rise) begin
         end_pend_d   = 1'b0;
         rom_loaded_d = 1'b0;
      end else begin
         if (dl_fall) end_pend_d = 1'b1;
         if (end_pend_q && state_q == S_IDLE && fifo_empty) begin
            rom_loaded_d = 1'b1;
            end_pend_d   = 1'b0;
         end
      end
      rst_cnt_d    = hold_rst ? RST_HOLD : ((rst_cnt_q != '0) ? rst_cnt_q - 16'd1 : rst_cnt_q);
      core_reset_d = hold_rst | (rst_cnt_q == 16'd1);
   end

   always_ff @(posedge clk_sys) begin
      if (push) fifo_mem_q[wr_ptr_q] <= {ioctl_addr, ioctl_dout};
   end

   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         wr_prev_q    <= 1'b0;
         dl_prev_q    <= 1'b0;
         end_pend_q   <= 1'b0;
         fifo_ovf_q   <= 1'b0;
         rom_loaded_q <= 1'b0;
         core_reset_q <= 1'b1;
         rst_cnt_q    <= RST_HOLD;
         port1_req_q  <= 1'b0;
         port1_a_q    <= '0;
         port1_ds_q   <= '0;
         port1_d_q    <= '0;
         port2_req_q  <= 1'b0;
         port2_a_q    <= '0;
         port2_ds_q   <= '0;
         port2_d_q    <= '0;
         dl_addr_q    <= '0;
         dl_data_q    <= '0;
         dl_wr_q      <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         wr_prev_q    <= ioctl_wr;
         dl_prev_q    <= ioctl_download;
         end_pend_q   <= end_pend_d;
         fifo_ovf_q   <= fifo_ovf_d;
         rom_loaded_q <= rom_loaded_d;
         core_reset_q <= core_reset_d;
         rst_cnt_q    <= rst_cnt_d;
         port1_req_q  <= port1_req_d;
         port1_a_q    <= port1_a_d;
         port1_ds_q   <= port1_ds_d;
         port1_d_q    <= port1_d_d;
         port2_req_q  <= port2_req_d;
         port2_a_q    <= port2_a_d;
         port2_ds_q   <= port2_ds_d;
         port2_d_q    <= port2_d_d;
         dl_addr_q    <= dl_addr_d;
         dl_data_q    <= dl_data_d;
         dl_wr_q      <= dl_wr_d;
      end
   end

`ifdef ROM_DL_CHECKSUM_EN
   logic [15:0] dl_sum_q, dl_sum_d;

   always_comb begin
      dl_sum_d = dl_sum_q;
      if (dl_rise)  dl_sum_d = '0;
      else if (pop) dl_sum_d = dl_sum_q + {8'h00, head_data};
   end

   always_ff @(posedge clk_sys) begin
      if (RESET) dl_sum_q <= '0;
      else       dl_sum_q <= dl_sum_d;
   end

   assign dl_sum = dl_sum_q;
`endif

   assign port1_req  = port1_req_q;
   assign port1_a    = port1_a_q;
   assign port1_ds   = port1_ds_q;
   assign port1_d    = port1_d_q;
   assign port2_req  = port2_req_q;
   assign port2_a    = port2_a_q;
   assign port2_ds   = port2_ds_q;
   assign port2_d    = port2_d_q;
   assign dl_addr    = dl_addr_q;
   assign dl_wr      = dl_wr_q;
   assign dl_data    = dl_data_q;
   assign fifo_ovf   = fifo_ovf_q;
   assign rom_loaded = rom_loaded_q;
   assign core_reset = core_reset_q;

endmodule

// File: tb/tb_rom_dl_dispatch.sv
// Directed bench for rom_dl_dispatch: routing, FIFO overflow, download end, reset generator, mid-transfer reset.
module tb_rom_dl_dispatch;

   logic        clk_sys = 1'b0;
   logic        RESET, ext_reset, ioctl_download, ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        port1_req, port1_ack, port2_req, port2_ack;
   logic [22:0] port1_a, port2_a;
   logic [1:0]  port1_ds, port2_ds;
   logic [15:0] port1_d, port2_d;
   logic [24:0] dl_addr;
   logic        dl_wr;
   logic [7:0]  dl_data;
   logic        fifo_ovf, rom_loaded, core_reset;
`ifdef ROM_DL_CHECKSUM_EN
   logic [15:0] dl_sum;
`endif

   int   checks   = 0;
   int   failures = 0;
   logic exp_r1   = 1'b0;
   logic exp_r2   = 1'b0;

   always #5 clk_sys = ~clk_sys;

   rom_dl_dispatch #(.SP_BASE(25'h12000), .DL_BASE(25'h32000), .FIFO_DEPTH(4), .RST_HOLD(16'd16)) dut (
      .clk_sys(clk_sys), .RESET(RESET), .ext_reset(ext_reset),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds), .port1_d(port1_d),
      .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a), .port2_ds(port2_ds), .port2_d(port2_d),
      .dl_addr(dl_addr), .dl_wr(dl_wr), .dl_data(dl_data),
      .fifo_ovf(fifo_ovf), .rom_loaded(rom_loaded), .core_reset(core_reset)
`ifdef ROM_DL_CHECKSUM_EN
      , .dl_sum(dl_sum)
`endif
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick(1);
      ioctl_wr   = 1'b0;
      tick(1);
   endtask

   task automatic test_reset;
      checks++; if (port1_req !== 1'b0) begin failures++; $display("FAIL rst_p1_req got=%b exp=0", port1_req); end
      checks++; if (port2_req !== 1'b0) begin failures++; $display("FAIL rst_p2_req got=%b exp=0", port2_req); end
      checks++; if (dl_wr !== 1'b0) begin failures++; $display("FAIL rst_dl_wr got=%b exp=0", dl_wr); end
      checks++; if ({fifo_ovf, rom_loaded} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {fifo_ovf, rom_loaded}); end
      checks++; if ({port1_a, port2_a, dl_addr} !== 71'd0) begin failures++; $display("FAIL rst_addrs got=%h exp=0", {port1_a, port2_a, dl_addr}); end
      checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL rst_core_reset got=%b exp=1", core_reset); end
   endtask

   task automatic test_p1;
      ioctl_addr = 25'h3; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
      tick(1);
      ioctl_wr = 1'b0;
      checks++; if (port1_req !== exp_r1) begin failures++; $display("FAIL p1_early_req got=%b exp=%b", port1_req, exp_r1); end
      tick(1);
      exp_r1 = ~exp_r1;
      checks++; if (port1_req !== exp_r1) begin failures++; $display("FAIL p1_req got=%b exp=%b", port1_req, exp_r1); end
      checks++; if (port1_a !== 23'h1) begin failures++; $display("FAIL p1_a got=%h exp=000001", port1_a); end
      checks++; if (port1_ds !== 2'b10) begin failures++; $display("FAIL p1_ds got=%b exp=10", port1_ds); end
      checks++; if (port1_d !== 16'h5A5A) begin failures++; $display("FAIL p1_d got=%h exp=5a5a", port1_d); end
      tick(3);
      checks++; if ({port1_req, port1_a} !== {exp_r1, 23'h1}) begin failures++; $display("FAIL p1_hold got=%h exp=%h", {port1_req, port1_a}, {exp_r1, 23'h1}); end
      port1_ack = exp_r1;
      tick(1);
   endtask

   task automatic test_p2;
      send_byte(25'h2A001, 8'h77);
      exp_r2 = ~exp_r2;
      checks++; if (port2_req !== exp_r2) begin failures++; $display("FAIL p2_req got=%b exp=%b", port2_req, exp_r2); end
      checks++; if (port2_a !== 23'h3) begin failures++; $display("FAIL p2_a got=%h exp=000003", port2_a); end
      checks++; if (port2_ds !== 2'b10) begin failures++; $display("FAIL p2_ds got=%b exp=10", port2_ds); end
      checks++; if (port2_d !== 16'h7777) begin failures++; $display("FAIL p2_d got=%h exp=7777", port2_d); end
      checks++; if (port1_req !== exp_r1) begin failures++; $display("FAIL p2_p1_quiet got=%b exp=%b", port1_req, exp_r1); end
      port2_ack = exp_r2;
      tick(1);
   endtask

   task automatic test_dl;
      int highs = 0;
      ioctl_addr = 25'h32010; ioctl_dout = 8'hC3; ioctl_wr = 1'b1;
      tick(1);
      checks++; if (dl_wr !== 1'b0) begin failures++; $display("FAIL dl_early got=%b exp=0", dl_wr); end
      tick(1);
      checks++; if ({dl_wr, dl_addr, dl_data} !== {1'b1, 25'h10, 8'hC3}) begin failures++; $display("FAIL dl_write got=%h exp=%h", {dl_wr, dl_addr, dl_data}, {1'b1, 25'h10, 8'hC3}); end
      tick(1);
      checks++; if (dl_wr !== 1'b0) begin failures++; $display("FAIL dl_pulse_end got=%b exp=0", dl_wr); end
      ioctl_wr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         if (dl_wr === 1'b1) highs++;
      end
      checks++; if (highs != 0) begin failures++; $display("FAIL dl_single_pulse got=%0d extra exp=0", highs); end
      checks++; if ({port1_req, port2_req} !== {exp_r1, exp_r2}) begin failures++; $display("FAIL dl_no_req got=%b exp=%b", {port1_req, port2_req}, {exp_r1, exp_r2}); end
   endtask

   task automatic test_boundary;
      logic [24:0] ba [4];
      logic [22:0] ea [4];
      logic [1:0]  eds [4];
      ba  = '{25'h11FFF, 25'h12000, 25'h31FFF, 25'h32000};
      ea  = '{23'h8FFF, 23'h0, 23'hFFFF, 23'h0};
      eds = '{2'b10, 2'b01, 2'b10, 2'b00};
      for (int i = 0; i < 4; i++) begin
         send_byte(ba[i], 8'(i + 1));
         if (i == 0) begin
            exp_r1 = ~exp_r1;
            checks++; if ({port1_req, port1_a, port1_ds} !== {exp_r1, ea[i], eds[i]}) begin failures++; $display("FAIL bnd_p1_%0d got=%h exp=%h", i, {port1_req, port1_a, port1_ds}, {exp_r1, ea[i], eds[i]}); end
            port1_ack = exp_r1;
         end else if (i < 3) begin
            exp_r2 = ~exp_r2;
            checks++; if ({port2_req, port2_a, port2_ds} !== {exp_r2, ea[i], eds[i]}) begin failures++; $display("FAIL bnd_p2_%0d got=%h exp=%h", i, {port2_req, port2_a, port2_ds}, {exp_r2, ea[i], eds[i]}); end
            port2_ack = exp_r2;
         end else begin
            checks++; if ({dl_wr, dl_addr, port1_req, port2_req} !== {1'b1, 25'h0, exp_r1, exp_r2}) begin failures++; $display("FAIL bnd_dl got=%h exp=%h", {dl_wr, dl_addr, port1_req, port2_req}, {1'b1, 25'h0, exp_r1, exp_r2}); end
         end
         tick(1);
      end
   endtask

   task automatic test_overflow;
      exp_r1 = ~exp_r1;
      for (int i = 0; i < 5; i++) send_byte(25'h200 + 25'(2 * i), 8'h10 + 8'(i));
      checks++; if (fifo_ovf !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", fifo_ovf); end
      send_byte(25'h20A, 8'h15);
      checks++; if (fifo_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", fifo_ovf); end
      for (int i = 0; i < 5; i++) begin
         checks++; if ({port1_req, port1_a, port1_d} !== {exp_r1, 23'h100 + 23'(i), {2{8'h10 + 8'(i)}}}) begin failures++; $display("FAIL ovf_order_%0d got=%h exp=%h", i, {port1_req, port1_a, port1_d}, {exp_r1, 23'h100 + 23'(i), {2{8'h10 + 8'(i)}}}); end
         port1_ack = exp_r1;
         tick(2);
         if (i < 4) exp_r1 = ~exp_r1;
      end
      tick(3);
      checks++; if (port1_req !== exp_r1) begin failures++; $display("FAIL ovf_dropped got=%b exp=%b", port1_req, exp_r1); end
      checks++; if (fifo_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", fifo_ovf); end
   endtask

   task automatic test_download_end;
      int lowc = 1;
      send_byte(25'h10, 8'hA1);
      exp_r1 = ~exp_r1;
      send_byte(25'h12, 8'hA2);
      ioctl_download = 1'b0;
      tick(3);
      checks++; if (rom_loaded !== 1'b0) begin failures++; $display("FAIL end_pending got=%b exp=0", rom_loaded); end
      port1_ack = exp_r1;
      tick(2);
      exp_r1 = ~exp_r1;
      checks++; if ({port1_req, port1_a, rom_loaded} !== {exp_r1, 23'h9, 1'b0}) begin failures++; $display("FAIL end_second got=%h exp=%h", {port1_req, port1_a, rom_loaded}, {exp_r1, 23'h9, 1'b0}); end
      port1_ack = exp_r1;
      tick(1);
      checks++; if ({rom_loaded, core_reset} !== 2'b01) begin failures++; $display("FAIL end_drain got=%b exp=01", {rom_loaded, core_reset}); end
      tick(1);
      checks++; if ({rom_loaded, core_reset} !== 2'b11) begin failures++; $display("FAIL end_loaded got=%b exp=11", {rom_loaded, core_reset}); end
      tick(1);
      checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL cr_fall got=%b exp=0", core_reset); end
      for (int k = 2; k <= 15; k++) begin
         tick(1);
         if (core_reset === 1'b0) lowc++;
      end
      checks++; if (lowc != 15) begin failures++; $display("FAIL cr_gap got=%0d exp=15", lowc); end
      tick(1);
      checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL cr_pulse got=%b exp=1", core_reset); end
      tick(1);
      checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL cr_pulse_end got=%b exp=0", core_reset); end
      tick(20);
      checks++; if ({rom_loaded, core_reset} !== 2'b10) begin failures++; $display("FAIL cr_settled got=%b exp=10", {rom_loaded, core_reset}); end
   endtask

   task automatic test_ext_reset;
      ext_reset = 1'b1;
      tick(1);
      checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL ext_on got=%b exp=1", core_reset); end
      ext_reset = 1'b0;
      tick(1);
      checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL ext_release got=%b exp=0", core_reset); end
      tick(14);
      checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL ext_gap got=%b exp=0", core_reset); end
      tick(1);
      checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL ext_pulse got=%b exp=1", core_reset); end
   endtask

   task automatic test_reset_mid;
      ioctl_download = 1'b1;
      tick(1);
      checks++; if (rom_loaded !== 1'b0) begin failures++; $display("FAIL rl_clear got=%b exp=0", rom_loaded); end
      send_byte(25'h12004, 8'h55);
      exp_r2 = ~exp_r2;
      checks++; if (port2_req !== exp_r2) begin failures++; $display("FAIL mid_issue got=%b exp=%b", port2_req, exp_r2); end
      send_byte(25'h40, 8'h99);
      RESET = 1'b1;
      tick(1);
      checks++; if ({port1_req, port2_req, core_reset, rom_loaded, fifo_ovf} !== 5'b00100) begin failures++; $display("FAIL mid_reset got=%b exp=00100", {port1_req, port2_req, core_reset, rom_loaded, fifo_ovf}); end
      checks++; if (port2_a !== 23'h0) begin failures++; $display("FAIL mid_reset_a got=%h exp=0", port2_a); end
`ifdef ROM_DL_CHECKSUM_EN
      checks++; if (dl_sum !== 16'h0) begin failures++; $display("FAIL mid_reset_sum got=%h exp=0", dl_sum); end
`endif
      RESET = 1'b0; port1_ack = 1'b0; port2_ack = 1'b0; exp_r1 = 1'b0; exp_r2 = 1'b0;
      tick(4);
      checks++; if ({port1_req, port2_req, dl_wr} !== 3'b000) begin failures++; $display("FAIL mid_flushed got=%b exp=000", {port1_req, port2_req, dl_wr}); end
      send_byte(25'h12002, 8'h66);
      checks++; if ({port2_req, port2_a, port2_ds} !== {1'b1, 23'h4, 2'b01}) begin failures++; $display("FAIL mid_idle_issue got=%h exp=%h", {port2_req, port2_a, port2_ds}, {1'b1, 23'h4, 2'b01}); end
`ifdef ROM_DL_CHECKSUM_EN
      checks++; if (dl_sum !== 16'h66) begin failures++; $display("FAIL mid_sum got=%h exp=0066", dl_sum); end
`endif
      port2_ack = 1'b1;
      tick(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; ext_reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_dout = '0; port1_ack = 1'b0; port2_ack = 1'b0;
      tick(3);
      test_reset();
      RESET = 1'b0;
      ioctl_download = 1'b1;
      tick(1);
      test_p1();
      test_p2();
      test_dl();
      test_boundary();
      test_overflow();
      test_download_end();
      test_ext_reset();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
